// File: rtl/wave_sequencer.sv
// wave_sequencer: waveform-ROM playback sequencer with active/shadow config and period-boundary updates
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   cmd_data        control byte {wave[7:6], gain[5:3], immediate[2], freq[1:0]}
//   cmd_valid       cmd_data valid
//   cmd_ready       a byte can be accepted (from state and shadow flag only)
//   run             1 = play, 0 = stop at the end of the current period
//   sample_div      clocks per sample minus 1
//   rom_en          one-clock ROM read strobe per sample
//   rom_addr        ROM address
//   wave_sel        active wave select
//   gain_sel        active gain code
//   step            active address increment (1, 2, 4 or 8)
//   sample_valid    rom_en delayed by ROM_LAT clocks
//   cycle_done      one-clock pulse on each address wrap
//   active          1 while playing (RUN or STOP)
module wave_sequencer #(
  parameter int ROM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  cmd_data,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        run,
  input  logic [15:0] sample_div,
  output logic        rom_en,
  output logic [8:0]  rom_addr,
  output logic [1:0]  wave_sel,
  output logic [2:0]  gain_sel,
  output logic [8:0]  step,
  output logic        sample_valid,
  output logic        cycle_done,
  output logic        active
);
  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;
  state_t state, state_nx;
  logic [15:0]        count;
  logic [6:0]         cfg;
  logic [6:0]         shadow;
  logic               shadow_full;
  logic [ROM_LAT-1:0] sv_pipe;
  logic               tick;
  logic               wrap;
  logic               accept;
  logic               direct;
  logic [9:0]         sum;
  assign cmd_ready    = (state == IDLE) || !shadow_full;
  assign accept       = cmd_valid && cmd_ready;
  // In IDLE every byte is applied at once; while playing only the immediate flag bypasses the shadow.
  assign direct       = accept && ((state == IDLE) || cmd_data[2]);
  assign tick         = (state != IDLE) && (count == sample_div);
  assign sum          = {1'b0, rom_addr} + step;
  assign wrap         = tick && sum[9];
  assign wave_sel     = cfg[6:5];
  assign gain_sel     = cfg[4:2];
  assign step         = 9'd1 << cfg[1:0];
  assign active       = state != IDLE;
  assign sample_valid = sv_pipe[ROM_LAT-1];
  // STOP returns to RUN whenever run is high, so only a wrap seen while already stopping ends playback.
  always_comb begin
    state_nx = run ? RUN : (state == IDLE || (state == STOP && wrap)) ? IDLE : STOP;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      rom_en      <= 1'b0;
      rom_addr    <= '0;
      cycle_done  <= 1'b0;
      sv_pipe     <= '0;
      cfg         <= '0;
      shadow      <= '0;
      shadow_full <= 1'b0;
    end else begin
      // A count left above a lowered sample_div restarts at 0 rather than running up to wrap.
      count      <= (state == IDLE || count >= sample_div) ? '0 : count + 16'd1;
      rom_en     <= tick;
      cycle_done <= wrap;
      sv_pipe    <= ROM_LAT'({sv_pipe, rom_en});
      if (tick) rom_addr <= (state_nx == IDLE) ? '0 : sum[8:0];
      if (direct) begin
        cfg         <= {cmd_data[7:3], cmd_data[1:0]};
        shadow_full <= 1'b0;
      end else begin
        // A deferred byte taken on a wrap edge can only land in an empty shadow, so it waits for the next wrap.
        if (wrap && shadow_full) cfg <= shadow;
        if (accept) begin
          shadow      <= {cmd_data[7:3], cmd_data[1:0]};
          shadow_full <= 1'b1;
        end else if (wrap) begin
          shadow_full <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_wave_sequencer.sv
// tb_wave_sequencer: directed and randomized checks of wave_sequencer against a behavioural playback model
module tb_wave_sequencer;
  localparam int LAT = 3;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        run;
  logic [15:0] sample_div;
  logic        rom_en;
  logic [8:0]  rom_addr;
  logic [1:0]  wave_sel;
  logic [2:0]  gain_sel;
  logic [8:0]  step;
  logic        sample_valid;
  logic        cycle_done;
  logic        active;
  int n_tests = 0;
  int n_fail  = 0;
  // Model: playback flags, sample phase, address, active config fields and a one-deep shadow queue.
  bit         m_play, m_stopping, m_en, m_cd, m_sv;
  int         m_cnt, m_addr, m_wave, m_gain, m_freq;
  logic [7:0] m_sh[$];
  bit         m_hist[$];
  wave_sequencer #(.ROM_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .run(run), .sample_div(sample_div), .rom_en(rom_en), .rom_addr(rom_addr), .wave_sel(wave_sel),
    .gain_sel(gain_sel), .step(step), .sample_valid(sample_valid), .cycle_done(cycle_done), .active(active)
  );
  always #5 clk = ~clk;
  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_play = 0; m_stopping = 0; m_en = 0; m_cd = 0; m_sv = 0;
    m_cnt = 0; m_addr = 0; m_wave = 0; m_gain = 0; m_freq = 0;
    m_sh.delete();
    m_hist.delete();
    for (int i = 0; i < LAT; i++) m_hist.push_back(1'b0);
  endtask
  task automatic apply_cfg(logic [7:0] b);
    m_wave = int'(b[7:6]);
    m_gain = int'(b[5:3]);
    m_freq = int'(b[1:0]);
  endtask
  task automatic check_all();
    check("rom_en", rom_en, m_en);
    check("rom_addr", rom_addr, m_addr);
    check("wave_sel", wave_sel, m_wave);
    check("gain_sel", gain_sel, m_gain);
    check("step", step, 1 << m_freq);
    check("sample_valid", sample_valid, m_sv);
    check("cycle_done", cycle_done, m_cd);
    check("active", active, m_play);
    check("cmd_ready", cmd_ready, !m_play || m_sh.size() == 0);
  endtask
  // Advance one clock: predict from the spec rules using pre-edge inputs, then compare after the edge.
  task automatic cycle();
    bit tk, wr, acc, to_idle;
    int nsum;
    int sd;
    sd      = int'(sample_div);
    acc     = cmd_valid && (!m_play || m_sh.size() == 0);
    tk      = m_play && (m_cnt == sd);
    nsum    = m_addr + (1 << m_freq);
    wr      = tk && (nsum >= 512);
    to_idle = !run && m_stopping && wr;
    m_cnt   = (!m_play || m_cnt >= sd) ? 0 : m_cnt + 1;
    if (tk) m_addr = to_idle ? 0 : nsum % 512;
    m_en = tk;
    m_cd = wr;
    if (acc && (!m_play || cmd_data[2])) begin
      apply_cfg(cmd_data);
      m_sh.delete();
    end else begin
      if (wr && m_sh.size() != 0) apply_cfg(m_sh.pop_front());
      if (acc) m_sh.push_back(cmd_data);
    end
    if (run) begin
      m_play = 1; m_stopping = 0;
    end else if (m_play) begin
      if (to_idle) begin m_play = 0; m_stopping = 0; end
      else m_stopping = 1;
    end
    m_hist.push_back(m_en);
    m_sv = m_hist.pop_front();
    @(posedge clk);
    #1;
    check_all();
  endtask
  task automatic send(logic [7:0] b);
    bit got = 0;
    int k = 0;
    cmd_data  = b;
    cmd_valid = 1'b1;
    while (!got && k < 3000) begin
      got = !m_play || m_sh.size() == 0;
      cycle();
      k++;
    end
    cmd_valid = 1'b0;
    check("send_accepted", got, 1'b1);
  endtask
  task automatic wait_addr(int target, int budget);
    int k = 0;
    while (m_addr != target && k < budget) begin
      cycle();
      k++;
    end
    check("wait_addr", rom_addr, target);
  endtask
  initial begin
    rst_n = 1'b0; cmd_data = '0; cmd_valid = 1'b0; run = 1'b0; sample_div = '0;
    model_reset();
    #2;
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // Full period at one sample per clock with step 1.
    send(8'h00);
    run = 1'b1;
    repeat (600) cycle();
    // Deferred wave 1 / step 8 issued mid-period.
    wait_addr(100, 600);
    send(8'h43);
    check("deferred_hold_step", step, 9'd1);
    repeat (520) cycle();
    check("deferred_applied_wave", wave_sel, 2'd1);
    check("deferred_applied_step", step, 9'd8);
    // Second deferred byte stalls on a full shadow until the wrap.
    send(8'h8A);
    send(8'hD1);
    repeat (300) cycle();
    check("second_deferred_step", step, 9'd2);
    check("second_deferred_wave", wave_sel, 2'd3);
    // Immediate step change mid-period leaves a non-multiple phase.
    send(8'h04);
    wait_addr(3, 600);
    send(8'h06);
    check("immediate_step", step, 9'd4);
    repeat (200) cycle();
    // Stop at end of period with a slower sample rate, then a stop cancelled before the wrap.
    send(8'h04);
    sample_div = 16'd3;
    wait_addr(500, 3000);
    run = 1'b0;
    repeat (60) cycle();
    check("stopped_active", active, 1'b0);
    check("stopped_addr", rom_addr, 9'd0);
    run = 1'b1;
    wait_addr(500, 3000);
    run = 1'b0;
    wait_addr(505, 100);
    run = 1'b1;
    repeat (100) cycle();
    check("resumed_active", active, 1'b1);
    // Randomized traffic: run toggles, byte stream and sample rate changes.
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 99) < 1) run = ~run;
      if ($urandom_range(0, 99) < 2) sample_div = 16'($urandom_range(0, 5));
      cmd_valid = ($urandom_range(0, 9) == 0);
      cmd_data  = 8'($urandom);
      cycle();
    end
    cmd_valid = 1'b0;
    // Asynchronous reset mid-run with a pending shadow entry.
    run = 1'b1;
    sample_div = 16'd0;
    send(8'h04);
    repeat (5) cycle();
    send(8'h43);
    check("shadow_full_before_reset", cmd_ready, 1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    run = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(8'h49);
    check("idle_direct_wave", wave_sel, 2'd1);
    check("idle_direct_step", step, 9'd2);
    check("idle_direct_gain", gain_sel, 3'd1);
    repeat (10) cycle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
